// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencing controller: load-use bubble insertion, branch/jump flush
// strobes, memory-wait freeze and stall/flush performance counters.
module hazard_flush_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemtoReg,
    input  logic             ex_RegWr,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_jump,
    input  logic             dmem_wait,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             Branch_fc,
    output logic             Jump_fc,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Bubbles remaining after the first one; only meaningful when more than one is needed.
    localparam logic [1:0] REM_INIT    = 2'(LOAD_STALL_CYCLES - 1);
    localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);

    state_t           state_reg, state_next;
    logic [1:0]       rem_reg, rem_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic             stall_inc, flush_inc;
    logic             hazard, flush_req;

    assign hazard = ex_MemtoReg & ex_RegWr & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign flush_req = mem_branch_taken | mem_jump;

    always_comb begin
        state_next  = state_reg;
        rem_next    = rem_reg;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        Branch_fc   = 1'b0;
        Jump_fc     = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (rst) begin
            state_next = RUN;
            rem_next   = 2'd0;
        end else if (dmem_wait) begin
            // Whole pipe frozen; a pending flush waits in MEM until memory is ready.
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            pipe_freeze = 1'b1;
        end else if (flush_req) begin
            // The load-dependent instruction is squashed, so any stall is dropped.
            Branch_fc  = mem_branch_taken;
            Jump_fc    = mem_jump & ~mem_branch_taken;
            flush_inc  = 1'b1;
            state_next = RUN;
            rem_next   = 2'd0;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (hazard) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        if (MULTI_STALL) begin
                            state_next = STALL;
                            rem_next   = REM_INIT;
                        end
                    end
                end
                STALL: begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    rem_next    = rem_reg - 2'd1;
                    if (rem_reg == 2'd1) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    rem_next   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            rem_reg       <= 2'd0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, stall_inc};
            flush_cnt_reg <= flush_cnt_reg + {{(CNT_W-1){1'b0}}, flush_inc};
        end
    end

    assign stall_active = (state_reg == STALL);
    assign stall_cnt    = stall_cnt_reg;
    assign flush_cnt    = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: two instances (1 and 3 bubbles per hazard)
// share the same stimulus; each cycle's expected outputs are queued and checked at negedge.
module tb_hazard_flush_ctrl;

    localparam int CNT_W = 32;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_MemtoReg, ex_RegWr;
    logic       mem_branch_taken, mem_jump, dmem_wait;

    logic             a_pc_hold, a_ifid_hold, a_idex_bubble, a_pipe_freeze;
    logic             a_Branch_fc, a_Jump_fc, a_stall_active;
    logic [CNT_W-1:0] a_stall_cnt, a_flush_cnt;
    logic             b_pc_hold, b_ifid_hold, b_idex_bubble, b_pipe_freeze;
    logic             b_Branch_fc, b_Jump_fc, b_stall_active;
    logic [CNT_W-1:0] b_stall_cnt, b_flush_cnt;

    hazard_flush_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump), .dmem_wait(dmem_wait),
        .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .idex_bubble(a_idex_bubble),
        .pipe_freeze(a_pipe_freeze), .Branch_fc(a_Branch_fc), .Jump_fc(a_Jump_fc),
        .stall_active(a_stall_active), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_flush_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr), .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump), .dmem_wait(dmem_wait),
        .pc_hold(b_pc_hold), .ifid_hold(b_ifid_hold), .idex_bubble(b_idex_bubble),
        .pipe_freeze(b_pipe_freeze), .Branch_fc(b_Branch_fc), .Jump_fc(b_Jump_fc),
        .stall_active(b_stall_active), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: {pc_hold, ifid_hold, idex_bubble, pipe_freeze, Branch_fc, Jump_fc, stall_active}
    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] BUB   = 7'b1110000;
    localparam logic [6:0] BUBS  = 7'b1110001;
    localparam logic [6:0] FRZ   = 7'b1101000;
    localparam logic [6:0] FRZS  = 7'b1101001;
    localparam logic [6:0] BRF   = 7'b0000100;
    localparam logic [6:0] BRFS  = 7'b0000101;
    localparam logic [6:0] JMF   = 7'b0000010;
    localparam logic [6:0] RSTS  = 7'b0000001;

    typedef struct {
        bit               sel;   // 0: dut1, 1: dut3
        string            tag;
        logic [6:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Drive one cycle of inputs just after the edge and queue what both outputs must show.
    task automatic vec(input bit chk, input bit sel, input string tag,
                       input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                       input bit mtr, input bit rw, input logic [4:0] ert,
                       input bit br, input bit jmp, input bit wt,
                       input logic [6:0] ctl, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = ur;
        ex_MemtoReg = mtr; ex_RegWr = rw; ex_rt = ert;
        mem_branch_taken = br; mem_jump = jmp; dmem_wait = wt;
        if (chk) begin
            e.sel = sel; e.tag = tag; e.ctl = ctl;
            e.sc = CNT_W'(sc); e.fc = CNT_W'(fc);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input bit sel, input string tag);
        vec(0, sel, tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
        vec(1, sel, tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] got_ctl;
        logic [CNT_W-1:0] got_sc, got_fc;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                got_ctl = {b_pc_hold, b_ifid_hold, b_idex_bubble, b_pipe_freeze,
                           b_Branch_fc, b_Jump_fc, b_stall_active};
                got_sc = b_stall_cnt; got_fc = b_flush_cnt;
            end else begin
                got_ctl = {a_pc_hold, a_ifid_hold, a_idex_bubble, a_pipe_freeze,
                           a_Branch_fc, a_Jump_fc, a_stall_active};
                got_sc = a_stall_cnt; got_fc = a_flush_cnt;
            end
            n_chk++;
            if (got_ctl !== e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl: got %b expected %b", e.tag, got_ctl, e.ctl);
            end
            n_chk++;
            if (got_sc !== e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, got_sc, e.sc);
            end
            n_chk++;
            if (got_fc !== e.fc) begin
                n_fail++;
                $display("FAIL %s flush_cnt: got %0d expected %0d", e.tag, got_fc, e.fc);
            end
            $display("check %s dut%0d ctl=%b stall_cnt=%0d flush_cnt=%0d",
                     e.tag, e.sel ? 3 : 1, got_ctl, got_sc, got_fc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_MemtoReg = 1'b0; ex_RegWr = 1'b0; ex_rt = '0;
        mem_branch_taken = 1'b0; mem_jump = 1'b0; dmem_wait = 1'b0;

        // 1: single bubble per hazard, plus back-to-back hazards
        do_reset(0, "t1_reset");
        vec(1, 0, "t1_haz",   0, 5, 0, 0, 1, 1, 5, 0, 0, 0, BUB,  0, 0);
        vec(1, 0, "t1_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 1, 0);
        vec(1, 0, "t1_b2b_a", 0, 5, 0, 0, 1, 1, 5, 0, 0, 0, BUB,  1, 0);
        vec(1, 0, "t1_b2b_b", 0, 5, 0, 0, 1, 1, 5, 0, 0, 0, BUB,  2, 0);
        vec(1, 0, "t1_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 3, 0);

        // 2: three bubbles on an rt dependence, restart after stall, non-hazards
        do_reset(1, "t2_reset");
        vec(1, 1, "t2_haz",   0, 0, 7, 1, 1, 1, 7, 0, 0, 0, BUB,  0, 0);
        vec(1, 1, "t2_bub2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUBS, 1, 0);
        vec(1, 1, "t2_bub3",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUBS, 2, 0);
        vec(1, 1, "t2_rehaz", 0, 0, 7, 1, 1, 1, 7, 0, 0, 0, BUB,  3, 0);
        vec(1, 1, "t2_rbub2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUBS, 4, 0);
        vec(1, 1, "t2_rbub3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUBS, 5, 0);
        vec(1, 1, "t2_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 6, 0);
        vec(1, 1, "t2_nort",  0, 0, 7, 0, 1, 1, 7, 0, 0, 0, IDLE, 6, 0);
        vec(1, 1, "t2_r0",    0, 0, 0, 1, 1, 1, 0, 0, 0, 0, IDLE, 6, 0);
        vec(1, 1, "t2_noreg", 0, 7, 0, 0, 1, 0, 7, 0, 0, 0, IDLE, 6, 0);
        vec(1, 1, "t2_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 6, 0);

        // 3: flush on the second bubble cancels the stall
        do_reset(1, "t3_reset");
        vec(1, 1, "t3_haz",   0, 5, 0, 0, 1, 1, 5, 0, 0, 0, BUB,  0, 0);
        vec(1, 1, "t3_flush", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BRFS, 1, 0);
        vec(1, 1, "t3_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 1, 1);
        vec(1, 1, "t3_run2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 1, 1);

        // 4: branch wins over jump; jump alone; one count per flush cycle
        vec(1, 1, "t4_both",  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, BRF,  1, 1);
        vec(1, 1, "t4_jump",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, JMF,  1, 2);
        vec(1, 1, "t4_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 1, 3);

        // 5: jump held under memory wait, then wait during a stall
        do_reset(1, "t5_reset");
        for (int i = 0; i < 4; i++)
            vec(1, 1, "t5_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, 0, 0);
        vec(1, 1, "t5_jump",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, JMF,  0, 0);
        vec(1, 1, "t5_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 1);
        vec(1, 1, "t5_whaz",  0, 5, 0, 0, 1, 1, 5, 0, 0, 1, FRZ,  0, 1);
        vec(1, 1, "t5_haz",   0, 5, 0, 0, 1, 1, 5, 0, 0, 0, BUB,  0, 1);
        vec(1, 1, "t5_swait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZS, 1, 1);
        vec(1, 1, "t5_bub2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUBS, 1, 1);
        vec(1, 1, "t5_bub3",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUBS, 2, 1);
        vec(1, 1, "t5_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 3, 1);

        // 6: reset in the middle of a stall, with hazard and flush inputs live
        vec(1, 1, "t6_haz",   0, 5, 0, 0, 1, 1, 5, 0, 0, 0, BUB,  3, 1);
        vec(1, 1, "t6_rst",   1, 5, 0, 0, 1, 1, 5, 1, 0, 0, RSTS, 4, 1);
        vec(1, 1, "t6_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);
        vec(1, 1, "t6_run2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU.
- Detects load-use hazards and inserts a programmable number of bubbles. Issues the branch/jump flush strobes (Branch_fc, Jump_fc) consumed by the IF/ID, ID/EX and EX/MEM segment registers.
- Freezes the whole pipe while data memory is busy.
- Keeps stall and flush performance counters.
- Sits beside the segment registers and drives their hold/clear inputs.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..3)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state updates on posedge clk
rst  in  1  synchronous reset, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_MemtoReg  in  1  instruction in EX is a load
ex_RegWr  in  1  instruction in EX writes a register
ex_rt  in  5  destination rt of instruction in EX
mem_branch_taken  in  1  branch in MEM resolved taken (from Zero/Sign/Branchctr)
mem_jump  in  1  jump in MEM (Jumpctr nonzero)
dmem_wait  in  1  data memory not ready; pipe must freeze
pc_hold  out  1  PC keeps value
ifid_hold  out  1  IF/ID keeps contents
idex_bubble  out  1  ID/EX loads all-zero (nop) control
pipe_freeze  out  1  ID/EX and EX/MEM hold contents
Branch_fc  out  1  taken-branch flush strobe
Jump_fc  out  1  jump flush strobe
stall_active  out  1  FSM in STALL state
stall_cnt  out  CNT_W  cycles with idex_bubble=1
flush_cnt  out  CNT_W  cycles with Branch_fc|Jump_fc=1

Behaviour:
- Outputs are combinational from registered state plus current inputs; state, stall counter and perf counters are registered.
- hazard = ex_MemtoReg & ex_RegWr & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- FSM states: RUN, STALL. Remaining-bubble counter rem (2 bits).
- Priority, highest first: rst > dmem_wait > flush > stall/hazard.
- rst=1: next state RUN, rem=0, stall_cnt=0, flush_cnt=0.
  - All outputs are combinational, so no output is registered.
  - While rst=1: pc_hold, ifid_hold, idex_bubble, pipe_freeze, Branch_fc, Jump_fc are forced 0.
  - After the reset edge: state RUN, rem=0, stall_active=0, stall_cnt=0, flush_cnt=0.
  - Reset mid-STALL abandons remaining bubbles.
- dmem_wait=1:
  - pipe_freeze=pc_hold=ifid_hold=1; idex_bubble=0; Branch_fc=Jump_fc=0.
  - State, rem and counters unchanged.
  - A pending branch/jump in MEM stays put because the pipe is frozen. Its flush is issued on the first cycle dmem_wait=0.
- Flush, with dmem_wait=0 and (mem_branch_taken | mem_jump):
  - Branch_fc=mem_branch_taken; Jump_fc=mem_jump&~mem_branch_taken.
  - pc_hold=ifid_hold=idex_bubble=0.
  - flush_cnt+1; next state RUN, rem=0. Any stall in progress is cancelled because the load-dependent instruction is squashed.
- RUN, no flush, hazard=1:
  - pc_hold=ifid_hold=idex_bubble=1; stall_cnt+1.
  - If LOAD_STALL_CYCLES==1: stay RUN. Otherwise go to STALL with rem=LOAD_STALL_CYCLES-1.
- STALL, no flush:
  - pc_hold=ifid_hold=idex_bubble=1; stall_cnt+1; rem-1.
  - When rem==1 this cycle, next state RUN.
  - hazard is not re-evaluated in STALL.
- RUN, no hazard, no flush, no wait: all control outputs 0.
- stall_active = (state==STALL).
- Counters wrap modulo 2^CNT_W with no saturation.
- Back-to-back hazards: a new hazard in RUN on the cycle after a stall ends starts a new stall.

Test Plan:
1. Load-use, LOAD_STALL_CYCLES=1: ex_MemtoReg=1, ex_RegWr=1, ex_rt=5, id_rs=5 for one cycle -> exactly one cycle of pc_hold=ifid_hold=idex_bubble=1; stall_cnt=1; state RUN.
2. Load-use on rt, LOAD_STALL_CYCLES=3:
   - ex_rt=7, id_rt=7, id_uses_rt=1 -> 3 consecutive bubble cycles; stall_active=1 on cycles 2-3; stall_cnt=3.
   - Repeat with id_uses_rt=0 -> no stall.
   - Repeat with ex_rt=0 -> no stall.
3. Flush mid-stall: LOAD_STALL_CYCLES=3, mem_branch_taken=1 on 2nd bubble cycle -> that cycle Branch_fc=1 and idex_bubble=0; next cycle RUN with outputs 0; stall_cnt=1, flush_cnt=1.
4. Branch and jump together -> Branch_fc=1, Jump_fc=0. Jump alone -> Jump_fc=1. flush_cnt increments once per cycle.
5. Flush during dmem_wait: mem_jump=1 with dmem_wait=1 for 4 cycles -> pipe_freeze=1, Jump_fc=0, counters static. Drop wait -> Jump_fc=1 that cycle; flush_cnt=1.
6. Reset mid-STALL, LOAD_STALL_CYCLES=3: rst=1 during 2nd bubble -> outputs 0 during rst; after reset edge state RUN, rem=0, stall_cnt=0, flush_cnt=0, no further bubbles.
